// File: rtl/handshake_pkg.sv
// Shared types and constants for the req/ack handshake responder.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs_resp_state_t;

    localparam int HS_TWO_PHASE  = 2;
    localparam int HS_FOUR_PHASE = 4;

endpackage

// File: rtl/ff_synchronizer.sv
// Multi-flop level synchronizer with asynchronous active-high reset.
module ff_synchronizer #(
    parameter int               WIDTH        = 1,
    parameter int               EXTRA_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam int STAGES = 2 + EXTRA_STAGES;

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= {STAGES{RESET_VALUE}};
        else       r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/handshake_responder.sv
// Receiving end of a 2-phase or 4-phase req/ack handshake; delivers each
// bundled word onto a local valid/ready stream and acks once it is taken.
module handshake_responder
    import handshake_pkg::*;
#(
    parameter int DWIDTH         = 8,
    parameter int EXTRA_STAGES   = 0,
    parameter int HANDSHAKE_TYPE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hs_req,
    input  logic [DWIDTH-1:0] hs_data,
    output logic              hs_ack,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready
);

    // Anything other than four-phase falls back to toggle signalling.
    localparam int TYPE_EFF = (HANDSHAKE_TYPE == HS_FOUR_PHASE) ? HS_FOUR_PHASE : HS_TWO_PHASE;

    logic              w_sync_rst;
    logic              w_req_s;
    logic              w_new_req;
    hs_resp_state_t    r_state;
    logic              r_ack;
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;

    assign w_sync_rst = ~reset;

    ff_synchronizer #(
        .WIDTH        (1),
        .EXTRA_STAGES (EXTRA_STAGES),
        .RESET_VALUE  (1'b0)
    ) u_req_sync (
        .i_clk (clk),
        .i_rst (w_sync_rst),
        .i_d   (hs_req),
        .o_q   (w_req_s)
    );

    generate
        if (TYPE_EFF == HS_FOUR_PHASE) begin : g_four_phase
            assign w_new_req = w_req_s & ~r_ack;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    case (r_state)
                        // hs_data is safe to sample raw: it settled before req got through the synchronizer
                        IDLE: if (w_new_req) begin
                            r_data  <= hs_data;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end
                        HOLD: if (r_valid && out_ready) begin
                            r_valid <= 1'b0;
                            r_ack   <= 1'b1;
                            r_state <= ACK;
                        end
                        ACK: if (!w_req_s) begin
                            r_ack   <= 1'b0;
                            r_state <= IDLE;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end else begin : g_two_phase
            // Pending whenever the levels differ; toggles seen in HOLD resurface in IDLE.
            assign w_new_req = w_req_s ^ r_ack;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    case (r_state)
                        IDLE: if (w_new_req) begin
                            r_data  <= hs_data;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end
                        HOLD: if (r_valid && out_ready) begin
                            r_valid <= 1'b0;
                            r_ack   <= ~r_ack;
                            r_state <= IDLE;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    endgenerate

    assign hs_ack    = r_ack;
    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: tb/tb_handshake_responder.sv
// Directed bench: three responder instances (2-phase, 4-phase, 2-phase with
// two extra sync stages), each driven by its own initiator/consumer signals.
module tb_handshake_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u2: type 2, EXTRA_STAGES=0
    logic       rst2, req2, rdy2, ack2, v2;
    logic [7:0] dat2, d2;
    // u4: type 4, EXTRA_STAGES=0
    logic       rst4, req4, rdy4, ack4, v4;
    logic [7:0] dat4, d4;
    // ue: type 2, EXTRA_STAGES=2
    logic       rste, reqe, rdye, acke, ve;
    logic [7:0] date, de;

    handshake_responder #(.DWIDTH(8), .EXTRA_STAGES(0), .HANDSHAKE_TYPE(2)) u2 (
        .clk(clk), .reset(rst2), .hs_req(req2), .hs_data(dat2), .hs_ack(ack2),
        .out_valid(v2), .out_data(d2), .out_ready(rdy2));
    handshake_responder #(.DWIDTH(8), .EXTRA_STAGES(0), .HANDSHAKE_TYPE(4)) u4 (
        .clk(clk), .reset(rst4), .hs_req(req4), .hs_data(dat4), .hs_ack(ack4),
        .out_valid(v4), .out_data(d4), .out_ready(rdy4));
    handshake_responder #(.DWIDTH(8), .EXTRA_STAGES(2), .HANDSHAKE_TYPE(2)) ue (
        .clk(clk), .reset(rste), .hs_req(reqe), .hs_data(date), .hs_ack(acke),
        .out_valid(ve), .out_data(de), .out_ready(rdye));

    int nvec = 0;
    int nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sent_q[$];
    logic [7:0] got_q[$];
    logic [7:0] wd, held;
    logic       start_ack, exp_ack, hold_chk;
    int         cyc;

    initial begin
        {rst2, req2, rdy2, dat2} = '0;
        {rst4, req4, rdy4, dat4} = '0;
        {rste, reqe, rdye, date} = '0;
        tick();
        chk("rst_u2", {ack2, v2, d2}, 10'h000);
        chk("rst_u4", {ack4, v4, d4}, 10'h000);
        chk("rst_ue", {acke, ve, de}, 10'h000);
        rst2 = 1'b1; rst4 = 1'b1; rste = 1'b1;
        tick();

        // 2-phase, out_ready high: one-cycle valid at edge 3, ack one edge later
        rdy2 = 1'b1; req2 = 1'b1; dat2 = 8'hA5;
        tick(); chk("t1_e1", {ack2, v2}, 2'b00);
        tick(); chk("t1_e2", {ack2, v2}, 2'b00);
        tick(); chk("t1_e3", {ack2, v2, d2}, {2'b01, 8'hA5});
        tick(); chk("t1_e4", {ack2, v2}, 2'b10);
        tick(); chk("t1_e5", {ack2, v2}, 2'b10);
        req2 = 1'b0; dat2 = 8'h3C;
        tick(); chk("t1b_e1", {ack2, v2}, 2'b10);
        tick(); chk("t1b_e2", {ack2, v2}, 2'b10);
        tick(); chk("t1b_e3", {ack2, v2, d2}, {2'b11, 8'h3C});
        tick(); chk("t1b_e4", {ack2, v2}, 2'b00);
        tick(); chk("t1b_e5", {ack2, v2}, 2'b00);

        // 4-phase, consumer stalls 10 cycles
        req4 = 1'b1; dat4 = 8'h5A;
        tick(); chk("t2_e1", {ack4, v4}, 2'b00);
        tick(); chk("t2_e2", {ack4, v4}, 2'b00);
        tick(); chk("t2_e3", {ack4, v4, d4}, {2'b01, 8'h5A});
        for (int i = 0; i < 10; i++) begin
            tick(); chk("t2_stall", {ack4, v4, d4}, {2'b01, 8'h5A});
        end
        rdy4 = 1'b1;
        tick(); chk("t2_accept", {ack4, v4}, 2'b10);
        // initiator keeps req high: responder parks in ACK
        for (int i = 0; i < 20; i++) begin
            tick(); chk("t3_park", {ack4, v4}, 2'b10);
        end
        req4 = 1'b0;
        tick(); chk("t2_drop1", {ack4, v4}, 2'b10);
        tick(); chk("t2_drop2", {ack4, v4}, 2'b10);
        tick(); chk("t2_drop3", {ack4, v4}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick(); chk("t2_nodup", {ack4, v4}, 2'b00);
        end

        // 2-phase protocol violation: req toggles back while word is held
        rdy2 = 1'b0; req2 = 1'b1; dat2 = 8'h11;
        tick(); tick(); tick();
        chk("t6_valid", {ack2, v2, d2}, {2'b01, 8'h11});
        req2 = 1'b0; dat2 = 8'h22;
        for (int i = 0; i < 6; i++) begin
            tick(); chk("t6_hold", {ack2, v2, d2}, {2'b01, 8'h11});
        end
        rdy2 = 1'b1;
        tick(); chk("t6_accept", {ack2, v2}, 2'b10);
        // levels now differ again, so the stray toggle is picked up as a request
        tick(); chk("t6_resume", {ack2, v2, d2}, {2'b11, 8'h22});
        tick(); chk("t6_ack2", {ack2, v2}, 2'b00);
        tick(); chk("t6_idle", {ack2, v2}, 2'b00);

        // 2-phase with 4 sync stages: valid at edge 5
        rdye = 1'b1; reqe = 1'b1; date = 8'h77;
        for (int i = 1; i <= 4; i++) begin
            tick(); chk("t4_lat", {acke, ve}, 2'b00);
        end
        tick(); chk("t4_e5", {acke, ve, de}, {2'b01, 8'h77});
        tick(); chk("t4_e6", {acke, ve}, 2'b10);

        // 100 random transfers with random consumer duty
        for (int w = 0; w < 100; w++) begin
            wd = 8'($urandom);
            sent_q.push_back(wd);
            date = wd;
            reqe = ~acke;
            start_ack = acke;
            cyc = 0;
            do begin
                rdye = ($urandom_range(0, 2) != 0);
                if (ve && rdye) got_q.push_back(de);
                hold_chk = ve && !rdye;
                held = de;
                tick();
                if (hold_chk) chk("t4_stable", {ve, de}, {1'b1, held});
                cyc++;
            end while (acke == start_ack && cyc < 100);
            exp_ack = ~start_ack;
            chk("t4_ack", acke, exp_ack);
        end
        chk("t4_count", got_q.size(), 100);
        for (int i = 0; i < 100; i++) begin
            if (i < got_q.size()) chk("t4_word", got_q[i], sent_q[i]);
        end

        // 4-phase reset in HOLD, req still high afterwards
        rdy4 = 1'b0; req4 = 1'b1; dat4 = 8'hC3;
        tick(); tick(); tick();
        chk("t5_hold", {ack4, v4, d4}, {2'b01, 8'hC3});
        #2 rst4 = 1'b0;
        #1 chk("t5_async", {ack4, v4, d4}, 10'h000);
        dat4 = 8'h96;
        tick(); chk("t5_inrst", {ack4, v4}, 2'b00);
        rst4 = 1'b1;
        tick(); chk("t5_r1", {ack4, v4}, 2'b00);
        tick(); chk("t5_r2", {ack4, v4}, 2'b00);
        tick(); chk("t5_r3", {ack4, v4, d4}, {2'b01, 8'h96});
        rdy4 = 1'b1;
        tick(); chk("t5_accept", {ack4, v4}, 2'b10);
        req4 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_final", {ack4, v4}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
